// File: rtl/note_sequencer.sv
// note_sequencer: plays a 3-bit score ROM as tone periods with start/pause/stop/loop control.
// Define NOTE_SEQUENCER_GAP_EN to add GAP_TIME silent cycles after every entry.
module note_sequencer #(
   parameter int CLK_PRE   = 50_000_000,
   parameter int BEAT_TIME = 20_000_000,
   parameter int GAP_TIME  = 2_500_000,
   parameter int SONG_LEN  = 93
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   input  logic        loop,
   output logic [2:0]  note_code,
   output logic [16:0] note_period,
   output logic        note_valid,
   output logic [6:0]  song_idx,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {
      IDLE,
      PLAY,
`ifdef NOTE_SEQUENCER_GAP_EN
      GAP,
`endif
      PAUSE
   } state_t;
   localparam int BW = BEAT_TIME > 1 ? $clog2(BEAT_TIME) : 1;
   // Entry 0 is the leftmost octal digit.
   localparam logic [383:0] SCORE = {
      48'o3356_1653_3216_5430, 48'o1233_2110_5665_3210,
      48'o3356_1653_3216_5430, 48'o6776_5432_1235_1000,
      48'o5556_5433_2123_5670, 48'o7654_3217_6540_1111,
      48'o3356_1653_3216_5430, 48'o1230_0000_0000_0000
   };
   localparam logic [16:0] PER [8] = '{
      17'd0, 17'(CLK_PRE / 523), 17'(CLK_PRE / 587), 17'(CLK_PRE / 659),
      17'(CLK_PRE / 698), 17'(CLK_PRE / 784), 17'(CLK_PRE / 880), 17'(CLK_PRE / 988)
   };
   function automatic logic [2:0] score(input logic [6:0] i);
      return SCORE[3 * (127 - int'(i)) +: 3];
   endfunction
   state_t        state, state_n;
   logic [6:0]    idx_n;
   logic [BW-1:0] beat, beat_n;
   logic          done_n, last;
   logic [2:0]    code_n;
`ifdef NOTE_SEQUENCER_GAP_EN
   localparam int GW = GAP_TIME > 1 ? $clog2(GAP_TIME) : 1;
   logic [GW-1:0] gap, gap_n;
   state_t        saved, saved_n;
`endif
   assign last   = song_idx == 7'(SONG_LEN - 1);
   assign code_n = (state_n == PLAY) ? score(idx_n) : 3'd0;
   always_comb begin
      state_n = state;
      idx_n   = song_idx;
      beat_n  = beat;
      done_n  = 1'b0;
`ifdef NOTE_SEQUENCER_GAP_EN
      gap_n   = gap;
      saved_n = saved;
`endif
      if (stop) begin
         state_n = IDLE;
         idx_n   = 7'd0;
         beat_n  = '0;
`ifdef NOTE_SEQUENCER_GAP_EN
         gap_n   = '0;
`endif
      end else if (pause && state == PAUSE) begin
`ifdef NOTE_SEQUENCER_GAP_EN
         state_n = saved;
`else
         state_n = PLAY;
`endif
      end else if (pause && state != IDLE) begin
         state_n = PAUSE;
`ifdef NOTE_SEQUENCER_GAP_EN
         saved_n = state;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               state_n = PLAY;
               idx_n   = 7'd0;
               beat_n  = '0;
            end
            PLAY: if (beat == BW'(BEAT_TIME - 1)) begin
               beat_n  = '0;
`ifdef NOTE_SEQUENCER_GAP_EN
               state_n = GAP;
               gap_n   = '0;
`else
               state_n = (last && !loop) ? IDLE : PLAY;
               idx_n   = last ? 7'd0 : song_idx + 7'd1;
               done_n  = last && !loop;
`endif
            end else begin
               beat_n = beat + 1'b1;
            end
`ifdef NOTE_SEQUENCER_GAP_EN
            GAP: if (gap == GW'(GAP_TIME - 1)) begin
               gap_n   = '0;
               state_n = (last && !loop) ? IDLE : PLAY;
               idx_n   = last ? 7'd0 : song_idx + 7'd1;
               done_n  = last && !loop;
            end else begin
               gap_n = gap + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end
   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         song_idx    <= 7'd0;
         beat        <= '0;
         note_code   <= 3'd0;
         note_period <= 17'd0;
         note_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef NOTE_SEQUENCER_GAP_EN
         gap         <= '0;
         saved       <= PLAY;
`endif
      end else begin
         state       <= state_n;
         song_idx    <= idx_n;
         beat        <= beat_n;
         note_code   <= code_n;
         note_period <= PER[code_n];
         note_valid  <= code_n != 3'd0;
         busy        <= state_n != IDLE;
         done        <= done_n;
`ifdef NOTE_SEQUENCER_GAP_EN
         gap         <= gap_n;
         saved       <= saved_n;
`endif
      end
   end
endmodule
